hpm_counter_bank: RTL and testbench
===================================

# hpm_counter_bank

Parametrised bank of event counters for the core's CSR unit: mcycle/minstret and the hpmcounter set. Each channel is a WIDTH-bit counter with its own increment-event and inhibit inputs. All channels sit behind one XLEN-wide read/write port that selects a channel and a half (low/high). The block generalises the single 32-bit up-counter to multi-channel, wide counters with split-half access, defined write/increment collision rules and optional overflow tracking.

## Interface
Parameters:
- CHANNELS, 4: number of counters; must be ≥ 1.
- XLEN, 32: access port width.
- WIDTH, 64: counter width; must satisfy XLEN < WIDTH ≤ 2*XLEN.
- SELW, $clog2(CHANNELS) (minimum 1): channel-select width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inc  in  CHANNELS  per-channel increment event for this cycle.
- inhibit  in  CHANNELS  per-channel count inhibit (mcountinhibit bits).
- sel  in  SELW  channel addressed by rd/we.
- hi  in  1  half select: 0 = bits [XLEN-1:0], 1 = bits [WIDTH-1:XLEN].
- we  in  1  write strobe for the selected channel/half.
- wd  in  XLEN  write data.
- rd  out  XLEN  read data of the selected channel/half.
- ovf  out  CHANNELS  sticky overflow flags; only present with the macro.
- ovf_clr  in  CHANNELS  per-channel flag clear; only present with the macro.
- irq  out  1  overflow interrupt request; only present with the macro.

## Operation
- Channel i counts when inc[i] && !inhibit[i]: cnt[i] <= cnt[i] + 1, modulo 2^WIDTH.
- Write, low half (we && !hi, sel == i):
  - cnt[i][XLEN-1:0] <= wd.
  - High half is held; no increment applies this cycle.
- Write, high half (we && hi, sel == i):
  - cnt[i][WIDTH-1:XLEN] <= wd[WIDTH-XLEN-1:0]; the upper bits of wd are ignored.
  - The low half still increments if enabled. Any carry out of the low half is discarded.
- Channels other than sel are unaffected by we.
- sel ≥ CHANNELS: writes are ignored and rd = 0.
- rd is combinational from the registered state:
  - hi = 0: low half of the selected counter.
  - hi = 1: high half, zero-extended to XLEN.
- Reset: every counter = 0, rd = 0 for any sel/hi, ovf = 0, irq = 0.

## Timing
- Writes and increments become visible on rd the cycle after the edge that performs them. rd never shows wd combinationally.
- Zero-latency read: a change to sel or hi updates rd in the same cycle.
- Wrap: a counter at 2^WIDTH-1 with a counting event (and no low write) becomes 0 at the next edge.
- A low-half carry rolls into the high half in the same edge. No cycle ever exposes a torn value internally.
- Reset asserted on the same edge as a write or increment: reset wins.

## Configuration
- HPM_OVF_IRQ_EN defined:
  - ovf[i] sets on the edge where channel i wraps from all-ones to 0 by increment.
  - A write that produces or passes through all-ones never sets the flag.
  - ovf_clr[i] clears ovf[i]. When set and clear coincide, set wins.
  - irq = |ovf, combinational from the flags, so it is asserted the cycle after the wrapping edge.
- HPM_OVF_IRQ_EN undefined:
  - Ports ovf, ovf_clr and irq do not exist and no flag registers are built.
  - Counters wrap silently.

## Test plan
- Reset, then inc = all-ones and inhibit = 0 for 10 cycles -> every channel reads 10 (hi = 0) and 0 (hi = 1). Assert reset for one cycle -> all channels read 0 next cycle.
- Channel 1 low half at 0xFFFF_FFFF, one increment -> low = 0x0000_0000 and high = 0x0000_0001 on the following cycle. Inhibit channel 1 -> value frozen while inc stays high.
- Channel 2 counting; write low = 0x1234 in the same cycle as an increment -> reads 0x1234 (not 0x1235). Write high = 0xAB in the same cycle as a low-half carry -> high = 0xAB and low = 0.
- WIDTH = 48: write high with wd = 0xFFFF_FFFF -> high reads 0x0000_FFFF. sel = CHANNELS with we = 1 -> no channel changes and rd = 0.
- With HPM_OVF_IRQ_EN: preload channel 0 to all-ones and increment -> ovf = 0b0001 and irq = 1 the next cycle. Assert ovf_clr[0] in the same cycle as a second wrap -> flag stays set. Assert ovf_clr[0] alone -> ovf = 0 and irq = 0.
- With HPM_OVF_IRQ_EN: write all-ones, then write 0 -> ovf stays 0.

Source files
------------

// File: rtl/hpm_counter_bank.sv
// rtl/hpm_counter_bank.sv - multi-channel WIDTH-bit event counters behind a split-half XLEN read/write port
// Optional overflow flags and interrupt are built when HPM_OVF_IRQ_EN is defined.
module hpm_counter_bank #(
  parameter int CHANNELS = 4,
  parameter int XLEN     = 32,
  parameter int WIDTH    = 64,
  parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] inc,
  input  logic [CHANNELS-1:0] inhibit,
  input  logic [SELW-1:0]     sel,
  input  logic                hi,
  input  logic                we,
  input  logic [XLEN-1:0]     wd,
`ifdef HPM_OVF_IRQ_EN
  output logic [CHANNELS-1:0] ovf,
  input  logic [CHANNELS-1:0] ovf_clr,
  output logic                irq,
`endif
  output logic [XLEN-1:0]     rd
);

  localparam int HW = WIDTH - XLEN;

  if (CHANNELS < 1) begin : g_bad_channels
    $error("hpm_counter_bank: CHANNELS must be at least 1");
  end
  if (!(XLEN < WIDTH && WIDTH <= 2 * XLEN)) begin : g_bad_width
    $error("hpm_counter_bank: WIDTH must satisfy XLEN < WIDTH <= 2*XLEN");
  end

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] wrap_w;

  // Only the low HW bits of wd reach the high half; the rest is ignored on purpose.
  logic unused_wd;
  assign unused_wd = ^wd;

  always_comb begin
    logic             en;
    logic             wsel;
    logic [XLEN-1:0]  lo_nxt;
    en     = 1'b0;
    wsel   = 1'b0;
    lo_nxt = '0;
    wrap_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      en       = inc[i] & ~inhibit[i];
      wsel     = we && (sel == SELW'(i));
      lo_nxt   = cnt_q[i][XLEN-1:0] + (en ? XLEN'(1) : XLEN'(0));
      if (wsel && !hi) begin
        cnt_d[i] = {cnt_q[i][WIDTH-1:XLEN], wd};
      end else if (wsel && hi) begin
        // Low half keeps counting, but its carry is dropped under the high write.
        cnt_d[i] = {wd[HW-1:0], lo_nxt};
      end else if (en) begin
        cnt_d[i]  = cnt_q[i] + WIDTH'(1);
        wrap_w[i] = &cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SELW'(i)) begin
        rd = hi ? XLEN'(cnt_q[i][WIDTH-1:XLEN]) : cnt_q[i][XLEN-1:0];
      end
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;

  assign ovf_d = (ovf_q & ~ovf_clr) | wrap_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
  assign irq = |ovf_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap_w;
`endif

endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb/tb_hpm_counter_bank.sv - directed self-checking bench for hpm_counter_bank (default and WIDTH=48 builds)
module tb_hpm_counter_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  inc;
  logic [3:0]  inhibit;
  logic [1:0]  sel;
  logic        hi;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] rd48;
`ifdef HPM_OVF_IRQ_EN
  logic [3:0]  ovf;
  logic [3:0]  ovf_clr;
  logic        irq;
  logic [2:0]  ovf48;
  logic        irq48;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hpm_counter_bank dut (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc),
    .inhibit (inhibit),
    .sel     (sel),
    .hi      (hi),
    .we      (we),
    .wd      (wd),
`ifdef HPM_OVF_IRQ_EN
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .irq     (irq),
`endif
    .rd      (rd)
  );

  hpm_counter_bank #(.CHANNELS(3), .XLEN(32), .WIDTH(48)) dut48 (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc[2:0]),
    .inhibit (inhibit[2:0]),
    .sel     (sel),
    .hi      (hi),
    .we      (we),
    .wd      (wd),
`ifdef HPM_OVF_IRQ_EN
    .ovf     (ovf48),
    .ovf_clr (ovf_clr[2:0]),
    .irq     (irq48),
`endif
    .rd      (rd48)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int s, input logic h, input logic [31:0] exp);
    sel = s[1:0];
    hi  = h;
    #1;
    chk(tag, rd, exp);
  endtask

  task automatic rd48_chk(input string tag, input int s, input logic h, input logic [31:0] exp);
    sel = s[1:0];
    hi  = h;
    #1;
    chk(tag, rd48, exp);
  endtask

  task automatic wr(input int s, input logic h, input logic [31:0] d);
    sel = s[1:0];
    hi  = h;
    wd  = d;
    we  = 1'b1;
    tick();
    we  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; inc = '0; inhibit = '0; sel = '0; hi = 1'b0; we = 1'b0; wd = '0;
`ifdef HPM_OVF_IRQ_EN
    ovf_clr = '0;
`endif
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rd_chk($sformatf("reset_lo_ch%0d", c), c, 1'b0, 32'h0);
      rd_chk($sformatf("reset_hi_ch%0d", c), c, 1'b1, 32'h0);
    end

    // Ten counting cycles on every channel.
    sel = 2'd0; hi = 1'b0;
    inc = 4'hF;
    for (int k = 0; k < 10; k++) tick();
    inc = 4'h0;
    for (int c = 0; c < 4; c++) begin
      rd_chk($sformatf("count10_lo_ch%0d", c), c, 1'b0, 32'd10);
      rd_chk($sformatf("count10_hi_ch%0d", c), c, 1'b1, 32'd0);
    end

    // Reset wins over simultaneous increments.
    inc = 4'hF; reset = 1'b1;
    tick();
    reset = 1'b0; inc = 4'h0;
    for (int c = 0; c < 4; c++) rd_chk($sformatf("rereset_lo_ch%0d", c), c, 1'b0, 32'h0);

    // Channel 1 low-half carry into high half, then inhibit.
    wr(1, 1'b0, 32'hFFFF_FFFF);
    inc = 4'b0010;
    tick();
    inc = 4'b0000;
    rd_chk("carry_lo_ch1", 1, 1'b0, 32'h0);
    rd_chk("carry_hi_ch1", 1, 1'b1, 32'h1);
    inc = 4'b0010; inhibit = 4'b0010;
    tick(); tick(); tick();
    inc = 4'b0000; inhibit = 4'b0000;
    rd_chk("inhibit_lo_ch1", 1, 1'b0, 32'h0);
    rd_chk("inhibit_hi_ch1", 1, 1'b1, 32'h1);

    // Channel 2: low write beats increment; high write with discarded carry.
    inc = 4'b0100;
    for (int k = 0; k < 5; k++) tick();
    sel = 2'd2; hi = 1'b0; wd = 32'h1234; we = 1'b1;
    #1;
    chk("no_comb_wd_ch2", rd, 32'd5);
    tick();
    we = 1'b0; inc = 4'b0000;
    rd_chk("lowwrite_vs_inc_ch2", 2, 1'b0, 32'h1234);
    wr(2, 1'b0, 32'hFFFF_FFFF);
    inc = 4'b0100;
    wr(2, 1'b1, 32'h0000_00AB);
    inc = 4'b0000;
    rd_chk("hiwrite_carry_hi_ch2", 2, 1'b1, 32'hAB);
    rd_chk("hiwrite_carry_lo_ch2", 2, 1'b0, 32'h0);

    // Channel 3 full wrap; other channels untouched by its writes.
    wr(3, 1'b0, 32'hFFFF_FFFF);
    wr(3, 1'b1, 32'hFFFF_FFFF);
    rd_chk("allones_hi_ch3", 3, 1'b1, 32'hFFFF_FFFF);
    inc = 4'b1000;
    tick();
    inc = 4'b0000;
    rd_chk("wrap_lo_ch3", 3, 1'b0, 32'h0);
    rd_chk("wrap_hi_ch3", 3, 1'b1, 32'h0);
    rd_chk("isolated_hi_ch2", 2, 1'b1, 32'hAB);
    rd_chk("isolated_lo_ch0", 0, 1'b0, 32'h0);

    // WIDTH=48, CHANNELS=3 instance.
    reset = 1'b1; tick(); reset = 1'b0;
    wr(0, 1'b1, 32'hFFFF_FFFF);
    rd48_chk("w48_hi_trunc_ch0", 0, 1'b1, 32'h0000_FFFF);
    wr(3, 1'b0, 32'h0000_0055);
    rd48_chk("w48_oob_rd", 3, 1'b0, 32'h0);
    rd48_chk("w48_oob_ch0_lo", 0, 1'b0, 32'h0);
    rd48_chk("w48_oob_ch0_hi", 0, 1'b1, 32'h0000_FFFF);
    rd48_chk("w48_oob_ch1_lo", 1, 1'b0, 32'h0);
    rd48_chk("w48_oob_ch2_lo", 2, 1'b0, 32'h0);
    wr(1, 1'b0, 32'hFFFF_FFFF);
    wr(1, 1'b1, 32'hFFFF_FFFF);
    inc = 4'b0010;
    tick();
    inc = 4'b0000;
    rd48_chk("w48_wrap_lo_ch1", 1, 1'b0, 32'h0);
    rd48_chk("w48_wrap_hi_ch1", 1, 1'b1, 32'h0);

`ifdef HPM_OVF_IRQ_EN
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    chk("ovf_reset", {28'h0, ovf}, 32'h0);
    chk("irq_reset", {31'h0, irq}, 32'h0);
    wr(0, 1'b0, 32'hFFFF_FFFF);
    wr(0, 1'b1, 32'hFFFF_FFFF);
    chk("ovf_after_ones_write", {28'h0, ovf}, 32'h0);
    inc = 4'b0001;
    tick();
    inc = 4'b0000;
    chk("ovf_set", {28'h0, ovf}, 32'h1);
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(0, 1'b0, 32'hFFFF_FFFF);
    wr(0, 1'b1, 32'hFFFF_FFFF);
    inc = 4'b0001; ovf_clr = 4'b0001;
    tick();
    inc = 4'b0000; ovf_clr = 4'b0000;
    chk("ovf_set_beats_clr", {28'h0, ovf}, 32'h1);
    ovf_clr = 4'b0001;
    tick();
    ovf_clr = 4'b0000;
    chk("ovf_cleared", {28'h0, ovf}, 32'h0);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    wr(1, 1'b0, 32'hFFFF_FFFF);
    wr(1, 1'b1, 32'hFFFF_FFFF);
    wr(1, 1'b0, 32'h0);
    wr(1, 1'b1, 32'h0);
    chk("ovf_write_passthrough", {28'h0, ovf}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
